// File: rtl/led_pattern_ctl_pkg.sv
// Shared constants for the LED pattern sequencer: mode codes, FSM states, ping-pong direction.
// FSM state encoding is deliberately identical to the mode code so cur_mode is the state itself.
package led_pattern_ctl_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ROT   = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PP    = 2'd3;

   typedef enum logic [1:0] {
      S_OFF   = MODE_OFF,
      S_ROT   = MODE_ROT,
      S_BLINK = MODE_BLINK,
      S_PP    = MODE_PP
   } state_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

endpackage

// File: rtl/led_pattern_ctl_if.sv
// Control/status bundle between the key control block (master) and the LED sequencer (slave).
interface led_pattern_ctl_if #(
   parameter int LED_WIDTH = 8
);
   logic [1:0]           mode;
   logic                 pause;
   logic [LED_WIDTH-1:0] led;
   logic [1:0]           cur_mode;
   logic                 tick;

   modport master (output mode, output pause, input led, input cur_mode, input tick);
   modport slave  (input mode, input pause, output led, output cur_mode, output tick);
endinterface

// File: rtl/led_pattern_ctl_tick_gen.sv
// Step prescaler: counts TICK_DIV cycles, emits a registered one-cycle tick after each wrap.
// wrap is the combinational wrap-edge strobe the pattern FSM steps on (same edge tick is set).
module tick_gen #(
   parameter logic [23:0] TICK_DIV = 24'd12_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic hold,
   output logic tick,
   output logic wrap
);
   localparam int            CW   = (TICK_DIV > 24'd1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 24'd1);

   logic [CW-1:0] cnt;

   // clr outranks everything, so a mode change on the wrap edge suppresses the step
   assign wrap = !clr && !hold && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         if (clr)        cnt <= '0;
         else if (!hold) cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_ctl.sv
// LED bank sequencer: samples the requested mode, reloads the pattern on every change,
// and steps off / rotate / blink / ping-pong on each prescaler wrap.
module led_pattern_ctl
   import led_pattern_ctl_pkg::*;
#(
   parameter int          LED_WIDTH = 8,
   parameter logic [23:0] TICK_DIV  = 24'd12_500_000
) (
   input  logic              clk,
   input  logic              rst_n,
   led_pattern_ctl_if.slave  bus
);
   localparam logic [LED_WIDTH-1:0] LED_ONE = {{(LED_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           mode_q;
   state_e               state, state_n;
   dir_e                 dir, dir_n;
   logic [LED_WIDTH-1:0] led_r, led_n;
   logic                 mode_chg, wrap, tick;

   assign mode_chg = (mode_q != state);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mode_chg),
      .hold  (bus.pause),
      .tick  (tick),
      .wrap  (wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_OFF;
         state  <= S_OFF;
         dir    <= DIR_LEFT;
         led_r  <= '0;
      end else begin
         mode_q <= bus.mode;
         state  <= state_n;
         dir    <= dir_n;
         led_r  <= led_n;
      end
   end

   always_comb begin
      state_n = state;
      dir_n   = dir;
      led_n   = led_r;
      if (mode_chg) begin
         state_n = state_e'(mode_q);
         dir_n   = DIR_LEFT;
         unique case (state_e'(mode_q))
            S_OFF:   led_n = '0;
            S_BLINK: led_n = '1;
            default: led_n = LED_ONE;
         endcase
      end else if (wrap) begin
         unique case (state)
            S_ROT:   led_n = {led_r[LED_WIDTH-2:0], led_r[LED_WIDTH-1]};
            S_BLINK: led_n = ~led_r;
            S_PP: begin
               // bounce off the end bit so the lit LED never leaves the bank
               if (dir == DIR_LEFT) begin
                  if (led_r[LED_WIDTH-1]) begin
                     dir_n = DIR_RIGHT;
                     led_n = led_r >> 1;
                  end else begin
                     led_n = led_r << 1;
                  end
               end else begin
                  if (led_r[0]) begin
                     dir_n = DIR_LEFT;
                     led_n = led_r << 1;
                  end else begin
                     led_n = led_r >> 1;
                  end
               end
            end
            default: led_n = '0;
         endcase
      end
   end

   assign bus.led      = led_r;
   assign bus.cur_mode = state;
   assign bus.tick     = tick;

endmodule
